clarvi_operand_gather: RTL
==========================

CLARVI_OPERAND_GATHER -- requirements
Module: clarvi_operand_gather

Interface
REQ-001 SHALL have parameter NUM_PARTS, default 8, giving the byte parts per full operand (64-bit).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, operand-fetch request present.
REQ-005 SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 SHALL have ports req_rs1 and req_rs2, input, 5 each, source register indices.
REQ-007 SHALL have port req_word, input, 1: 1 = 32-bit operands, sign-extended to 64 bits.
REQ-008 SHALL have port rf_fetch_part, output, 3, byte part driven to the register file.
REQ-009 SHALL have ports rf_fetch_register_1 and rf_fetch_register_2, output, 5 each, register indices driven to the register file.
REQ-010 SHALL have ports rf_data_1 and rf_data_2, input, 8 each, combinational register-file read bytes for the current part.
REQ-011 SHALL have port op_valid, output, 1, assembled operands available.
REQ-012 SHALL have port op_ready, input, 1, consumer accepts the operands.
REQ-013 SHALL have ports op_rs1 and op_rs2, output, 64 each, assembled operands.

Function
REQ-014 SHALL implement the FSM states IDLE, GATHER and HOLD.
REQ-015 IDLE: req_ready=1 and op_valid=0; when req_valid=1, SHALL latch rs1, rs2 and word, clear the part counter, and enter GATHER.
REQ-016 GATHER: req_ready=0; rf_fetch_part=counter; rf_fetch_register_1/2 = the latched indices; each cycle SHALL write rf_data_1/2 into byte [8*counter +: 8] of op_rs1/op_rs2.
REQ-017 The last part is NUM_PARTS-1 when word=0 and 3 when word=1; on the last part SHALL enter HOLD, otherwise SHALL increment the counter.
REQ-018 In word mode, on the last-part edge SHALL fill bytes 4..7 with bit 7 of that cycle's byte 3 (sign extension), per operand independently.
REQ-019 HOLD: op_valid=1 and req_ready=0; when op_ready=1, SHALL return to IDLE; op_rs1/op_rs2 SHALL stay stable while op_valid=1.
REQ-020 Latency: a request accepted on edge T SHALL give op_valid=1 after edge T+8 (64-bit) or T+4 (word), given 1 cycle per part.
REQ-021 No request SHALL be accepted in HOLD or GATHER; req_valid in those states is ignored, and the requester holds it.
REQ-022 In IDLE, rf_fetch_part=0 and the register outputs hold the last latched indices.
REQ-023 op_rs1/op_rs2 SHALL retain their last values in IDLE; bytes are overwritten only in GATHER.
REQ-024 Register 0 SHALL get no special handling; the register file returns zero, and the full part sequence still runs.
REQ-025 There is no write forwarding; each byte is the value read in its GATHER cycle. Writes to a source register mid-gather are the issuer's responsibility.
REQ-026 rs1 == rs2 SHALL be legal and yield identical operands.

Reset
REQ-027 While reset_n=0, asynchronously: state=IDLE, counter=0, latched indices=0, op_rs1=op_rs2=0, op_valid=0, req_ready=1, rf_fetch_part=0.
REQ-028 Reset asserted in GATHER or HOLD SHALL abort the operation; the partial operand is discarded and no op_valid pulse occurs.
REQ-029 After reset_n rises, the first rising clock edge SHALL be able to accept a request.

Verification
REQ-030 x5=0x0123456789ABCDEF, x6=0xFEDCBA9876543210, req(rs1=5, rs2=6, word=0) -> op_valid after 8 GATHER cycles with rf_fetch_part 0..7 in order, op_rs1=0x0123456789ABCDEF, op_rs2=0xFEDCBA9876543210.
REQ-031 x7=0x00000000_80000001, req(rs1=7, rs2=0, word=1) -> 4 GATHER cycles, op_rs1=0xFFFFFFFF80000001, op_rs2=0.
REQ-032 Hold op_ready=0 for 5 cycles in HOLD -> op_valid stays 1, operands stable, req_ready=0, a pending req_valid is not accepted; op_ready=1 -> IDLE next edge.
REQ-033 reset_n pulsed low during GATHER part 3 -> outputs zero immediately; no op_valid; the next request completes correctly.
REQ-034 Back-to-back requests (req_valid held high, op_ready=1) -> each accepted in IDLE only; throughput of one 64-bit pair per 10 cycles, with correct data per request.

Source files
------------

// File: rtl/clarvi_operand_gather.sv
// rtl/clarvi_operand_gather.sv - byte-serial operand gather from a narrow register file
//
// Fetches two source operands one byte part per cycle from a register file
// that has an 8-bit read port per source. The bytes are assembled into two
// 64-bit operands. In word mode only parts 0..3 are fetched, and each operand
// is sign-extended from its bit 31.
//
// Ports:
//   clock, reset_n                     clock, asynchronous active-low reset
//   req_valid/req_ready                operand-fetch request handshake
//   req_rs1, req_rs2, req_word         source indices and 32-bit mode flag
//   rf_fetch_part                      byte part presented to the register file
//   rf_fetch_register_1/2              register indices presented to the register file
//   rf_data_1, rf_data_2               combinational read bytes for the current part
//   op_valid/op_ready                  assembled-operand handshake
//   op_rs1, op_rs2                     assembled 64-bit operands

module clarvi_operand_gather #(
  parameter int NUM_PARTS = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic        req_word,
  output logic [2:0]  rf_fetch_part,
  output logic [4:0]  rf_fetch_register_1,
  output logic [4:0]  rf_fetch_register_2,
  input  logic [7:0]  rf_data_1,
  input  logic [7:0]  rf_data_2,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [63:0] op_rs1,
  output logic [63:0] op_rs2
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATHER = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_FULL = 3'(NUM_PARTS - 1);
  localparam logic [2:0] LAST_WORD = 3'd3;

  state_t      r_state;
  logic [2:0]  r_counter;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic        r_word;
  logic [63:0] r_op_rs1;
  logic [63:0] r_op_rs2;
  logic        r_req_ready;
  logic        r_op_valid;

  logic        w_last;
  logic [5:0]  w_bit_base;

  assign w_last     = r_word ? (r_counter == LAST_WORD) : (r_counter == LAST_FULL);
  assign w_bit_base = {r_counter, 3'b000};

  // Handshake flags are registered alongside the state so they never glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_counter   <= 3'd0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_word      <= 1'b0;
      r_op_rs1    <= 64'd0;
      r_op_rs2    <= 64'd0;
      r_req_ready <= 1'b1;
      r_op_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_rs1       <= req_rs1;
            r_rs2       <= req_rs2;
            r_word      <= req_word;
            r_counter   <= 3'd0;
            r_req_ready <= 1'b0;
            r_state     <= S_GATHER;
          end
        end

        S_GATHER: begin
          r_op_rs1[w_bit_base +: 8] <= rf_data_1;
          r_op_rs2[w_bit_base +: 8] <= rf_data_2;
          if (w_last) begin
            // Byte 3 is arriving on this very edge, so its sign bit comes
            // straight from the read port rather than the operand register.
            if (r_word) begin
              r_op_rs1[63:32] <= {32{rf_data_1[7]}};
              r_op_rs2[63:32] <= {32{rf_data_2[7]}};
            end
            // Counter parks at 0 so rf_fetch_part reads 0 outside GATHER.
            r_counter  <= 3'd0;
            r_op_valid <= 1'b1;
            r_state    <= S_HOLD;
          end else begin
            r_counter <= r_counter + 3'd1;
          end
        end

        S_HOLD: begin
          if (op_ready) begin
            r_op_valid  <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_counter   <= 3'd0;
          r_op_valid  <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready           = r_req_ready;
  assign op_valid            = r_op_valid;
  assign rf_fetch_part       = r_counter;
  assign rf_fetch_register_1 = r_rs1;
  assign rf_fetch_register_2 = r_rs2;
  assign op_rs1              = r_op_rs1;
  assign op_rs2              = r_op_rs2;

endmodule
